// File: rtl/pred_pkg.sv
// Shared types and helpers for the saturating-counter branch predictor.
// Counter math is done in 32 bits so one helper serves every counter width.
package pred_pkg;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    function automatic int unsigned ctr_init(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    function automatic int unsigned sat_next(
        input int unsigned ctr,
        input logic        taken,
        input int unsigned width
    );
        int unsigned max_v;
        max_v = (32'd1 << width) - 32'd1;
        if (taken) begin
            return (ctr >= max_v) ? max_v : ctr + 32'd1;
        end
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/sat_ctr_next.sv
// Combinational saturating increment/decrement of one predictor counter.
// Shared by the table write path and the same-index read bypass.
module sat_ctr_next
    import pred_pkg::*;
#(
    parameter int CTR_WIDTH = 2
) (
    input  logic [CTR_WIDTH-1:0] ctr_i,
    input  logic                 taken_i,
    output logic [CTR_WIDTH-1:0] ctr_o
);

    assign ctr_o = CTR_WIDTH'(sat_next(32'(ctr_i), taken_i, CTR_WIDTH));

endmodule

// File: rtl/sat_counter_predictor_table.sv
// Branch direction predictor: table of saturating counters, bimodal or gshare
// indexing, one-cycle registered prediction, resolution-time update.
module sat_counter_predictor_table
    import pred_pkg::*;
#(
    parameter int CTR_WIDTH  = 2,
    parameter int INDEX_BITS = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int HIST_BITS  = 4,
    parameter int MODE       = 0,
    parameter int MISS_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [CTR_WIDTH-1:0]  pred_ctr,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    input  logic                  upd_mispred,
    output logic [MISS_WIDTH-1:0] miss_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_WIDTH-1:0] WEAK_NT = CTR_WIDTH'(ctr_init(CTR_WIDTH));

    logic [CTR_WIDTH-1:0]  ctr_q [ENTRIES];
    logic [CTR_WIDTH-1:0]  ctr_d [ENTRIES];
    logic [HIST_BITS-1:0]  ghr_q, ghr_d;
    logic [MISS_WIDTH-1:0] miss_q, miss_d;

    logic                  pred_valid_q, pred_valid_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [CTR_WIDTH-1:0]  pred_ctr_q, pred_ctr_d;
    logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;

    logic [INDEX_BITS-1:0] req_idx;
    logic [CTR_WIDTH-1:0]  upd_next;
    logic [CTR_WIDTH-1:0]  rd_ctr;
    logic                  bypass;
    logic                  unused_addr;

    // Upper address bits do not take part in indexing.
    assign unused_addr = ^req_addr;

    assign req_idx = (MODE == MODE_GSHARE)
                   ? req_addr[INDEX_BITS-1:0] ^ INDEX_BITS'(ghr_q)
                   : req_addr[INDEX_BITS-1:0];

    sat_ctr_next #(
        .CTR_WIDTH (CTR_WIDTH)
    ) u_upd_next (
        .ctr_i   (ctr_q[upd_index]),
        .taken_i (upd_taken),
        .ctr_o   (upd_next)
    );

    assign bypass = upd_valid && (upd_index == req_idx);
    assign rd_ctr = bypass ? upd_next : ctr_q[req_idx];

    always_comb begin
        ctr_d = ctr_q;
        if (upd_valid) begin
            ctr_d[upd_index] = upd_next;
        end
    end

    always_comb begin
        ghr_d = ghr_q;
        if (MODE == MODE_GSHARE && upd_valid) begin
            ghr_d = HIST_BITS'({ghr_q, upd_taken});
        end
    end

    always_comb begin
        miss_d = miss_q;
        if (upd_valid && upd_mispred && !(&miss_q)) begin
            miss_d = miss_q + 1'b1;
        end
    end

    always_comb begin
        pred_valid_d = req_valid;
        pred_taken_d = pred_taken_q;
        pred_ctr_d   = pred_ctr_q;
        pred_index_d = pred_index_q;
        if (req_valid) begin
            pred_ctr_d   = rd_ctr;
            pred_taken_d = rd_ctr[CTR_WIDTH-1];
            pred_index_d = req_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= WEAK_NT;
            end
            ghr_q        <= '0;
            miss_q       <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_ctr_q   <= '0;
            pred_index_q <= '0;
        end else begin
            ctr_q        <= ctr_d;
            ghr_q        <= ghr_d;
            miss_q       <= miss_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_ctr_q   <= pred_ctr_d;
            pred_index_q <= pred_index_d;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_ctr   = pred_ctr_q;
    assign pred_index = pred_index_q;
    assign miss_count = miss_q;

endmodule
